// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - sequencer state codes, key codes, operator codes and entry FSM type
package operand_entry_pkg;

  // Sequencer state codes shared with the rest of the calculator
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXECA   = 3'd1;
  localparam logic [2:0] EXECB   = 3'd2;
  localparam logic [2:0] EXECC   = 3'd3;
  localparam logic [2:0] DISPLAY = 3'd4;

  // Keypad codes above the digits 0-9
  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  // Operator codes presented to the ALU stage
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    E_A    = 2'd0,
    E_B    = 2'd1,
    E_DONE = 2'd2
  } entry_t;

  // Map an operator key to the ALU operator code
  function automatic logic [1:0] op_of_key(input logic [3:0] k);
    logic [1:0] r;
    case (k)
      KEY_SUB: r = OP_SUB;
      KEY_MUL: r = OP_MUL;
      KEY_DIV: r = OP_DIV;
      default: r = OP_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/operand_entry_decimal_accumulator.sv
// rtl/operand_entry_decimal_accumulator.sv - decimal digit accumulator with digit-count limit
module decimal_accumulator #(
  parameter int DIGITS = 4,
  parameter int W      = 14,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          digit_en,
  input  logic [3:0]    digit,
  output logic [W-1:0]  value,
  output logic [CW-1:0] count,
  output logic          nonempty
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(DIGITS);

  // value*10 + digit; only the low W bits are kept, which equals the
  // W+4-bit product truncated to W and never wraps for legal W
  logic [W-1:0] next_value;
  assign next_value = (value << 3) + (value << 1) + {{(W-4){1'b0}}, digit};

  assign nonempty = (count != '0);

  // Accept a digit while below the digit limit; extra digits are dropped silently
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      value <= '0;
      count <= '0;
    end else if (digit_en && (count < MAX_COUNT)) begin
      value <= next_value;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - keypad operand/operator entry stage feeding the ALU
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [2:0]   state,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] opa,
  output logic [W-1:0] opb,
  output logic [1:0]   op,
  output logic         inputed
);

  localparam int CW = $clog2(DIGITS + 1);

  entry_t        fsm;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          ne_a;
  logic          ne_b;
  logic          cnt_unused;

  // Counts are available for debug; the FSM only needs the nonempty flags
  assign cnt_unused = ^{cnt_a, cnt_b};

  // A key acts only in EXECA and never once entry is complete
  logic live;
  logic is_digit;
  logic is_oper;
  logic clr_all;

  assign live     = key_valid && (state == EXECA) && (fsm != E_DONE);
  assign is_digit = (key_code <= 4'd9);
  assign is_oper  = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign clr_all  = (state == IDLE) || (live && (key_code == KEY_CLR));

  decimal_accumulator #(.DIGITS(DIGITS), .W(W), .CW(CW)) u_acc_a (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (clr_all),
    .digit_en (live && (fsm == E_A) && is_digit),
    .digit    (key_code),
    .value    (opa),
    .count    (cnt_a),
    .nonempty (ne_a)
  );

  decimal_accumulator #(.DIGITS(DIGITS), .W(W), .CW(CW)) u_acc_b (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (clr_all),
    .digit_en (live && (fsm == E_B) && is_digit),
    .digit    (key_code),
    .value    (opb),
    .count    (cnt_b),
    .nonempty (ne_b)
  );

  // Entry FSM: operator moves A->B once A has a digit, '=' completes once B has a digit
  always_ff @(posedge CLK) begin
    if (RST || clr_all) begin
      fsm     <= E_A;
      op      <= OP_ADD;
      inputed <= 1'b0;
    end else if (live) begin
      case (fsm)
        E_A: begin
          if (is_oper && ne_a) begin
            op  <= op_of_key(key_code);
            fsm <= E_B;
          end
        end
        E_B: begin
          if (is_oper && !ne_b) begin
            op <= op_of_key(key_code);
          end else if ((key_code == KEY_EQ) && ne_b) begin
            fsm     <= E_DONE;
            inputed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Operand entry stage of the calculator. It consumes single-cycle key events from the keypad scanner while the top-level sequencer is in the input-phase state code `EXECA`. It accumulates decimal operand A, an operator and decimal operand B, then raises `inputed` so the sequencer advances to the compute phase. Operands and operator stay stable on its outputs for the downstream ALU stage until the sequencer returns to `IDLE`.

## Interface
- `DIGITS`, default 4: maximum decimal digits per operand.
- `W`, default 14: binary operand width; must satisfy 10^DIGITS − 1 < 2^W.
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `state`  in  3  sequencer state code (`IDLE`, `EXECA`, …).
- `key_valid`  in  1  one-cycle pulse per key press.
- `key_code`  in  4  0–9 digit, 10 `+`, 11 `-`, 12 `*`, 13 `/`, 14 `=`, 15 CLR; sampled only when `key_valid`=1.
- `opa`  out  W  operand A, unsigned binary.
- `opb`  out  W  operand B, unsigned binary.
- `op`  out  2  operator: 00 add, 01 sub, 10 mul, 11 div.
- `inputed`  out  1  level: entry complete; operands valid.

## Operation
- Internal entry FSM: `E_A` (entering A), `E_B` (entering B), `E_DONE`. Per-operand digit counters `cnt_a`, `cnt_b` (0..DIGITS).
- Reset, or any cycle with `state`==`IDLE`: FSM→`E_A`, `opa`=`opb`=0, `op`=00, `cnt_a`=`cnt_b`=0, `inputed`=0. `RST` takes priority over everything.
- A key is accepted only when `key_valid`=1 and `state`==`EXECA`. Otherwise it is dropped.
- In `E_A`:
  - Digit d with `cnt_a`<DIGITS: `opa`←`opa`·10+d, `cnt_a`+1. Digits beyond DIGITS are ignored, with no error flag.
  - Operator key with `cnt_a`≥1: latch `op`, go to `E_B`. Ignored when `cnt_a`=0.
  - `=` is ignored.
- In `E_B`:
  - Digits accumulate into `opb`/`cnt_b` under the same rule.
  - Operator key with `cnt_b`=0 replaces `op`. Ignored when `cnt_b`≥1.
  - `=` with `cnt_b`≥1: go to `E_DONE`, `inputed`←1. Ignored when `cnt_b`=0.
- In `E_DONE`: all keys, including CLR, are ignored. Outputs are frozen. Exit only by `RST` or `state`==`IDLE`.
- CLR in `E_A`/`E_B`: same clear as reset, FSM→`E_A`.
- Leading zeros count as digits. "007" occupies 3 of DIGITS.
- Multiply-by-10 is (x<<3)+(x<<1) in W+4 bits, truncated to W. It never overflows given the `W` constraint.

## Timing
- Accepted key at edge k: the register update (`opa`/`opb`/`op`/FSM) is visible after edge k. Latency is 1 cycle.
- `inputed` rises in the cycle after the accepting `=` edge. It holds high through `EXECB`/`EXECC`/`DISPLAY` and drops the cycle after `state`==`IDLE` is sampled.
- One key per cycle. Back-to-back `key_valid` pulses on consecutive cycles are all accepted.
- `key_valid` held high for N cycles counts as N presses. Pulse shaping is the scanner's job.
- If `state` leaves `EXECA` mid-entry (not to `IDLE`), partial values are held and keys are ignored. Entry resumes on return to `EXECA`.

## Structure
- Shared header `calc_defs.vh` holds the state codes, plus new key-code constants (`KEY_ADD`…`KEY_CLR`) and operator codes (`OP_ADD`…`OP_DIV`). The header is consumed by the ALU stage too.
- One sub-module, `decimal_accumulator`, with parameters `DIGITS` and `W`. Inputs: clear, digit-enable, digit. Outputs: value, count, nonempty. Instantiated twice, for A and B.
- Entry FSM and key decode live in `operand_entry`.

## Test plan
- Reset, then `state`=`EXECA`; keys 1,2,`+`,3,4,`=` → `opa`=12, `opb`=34, `op`=00, `inputed`=1 one cycle after the `=` edge.
- Keys 9,8,7,6,5 (DIGITS=4), `*`, 9,9,9,9, `=` → `opa`=9876, `opb`=9999, `op`=10.
- `+` first, `=` with empty B, `-` then `/` before B digits → leading `+` ignored, `=` ignored, final `op`=11.
- Keys 4,`-`,2, CLR, 5,`+`,1,`=` → `opa`=5, `opb`=1, `op`=00.
- Entry complete; then keys 7 and CLR; then `state`=`IDLE` → outputs unchanged until `IDLE`, then all zero and `inputed`=0 the next cycle.
- Keys pulsed while `state`=`IDLE` or `EXECB` → no change. `RST` asserted mid-entry → all outputs 0 after that edge.
